upcounter_2d_ctrl: RTL and testbench



---
 rtl/upcounter_2d_ctrl_pkg.sv | 28 ++
 rtl/upcounter_2d_ctrl_bcd_upcounter.sv | 33 +++
 rtl/upcounter_2d_ctrl.sv | 150 +++++++++++++++
 tb/tb_upcounter_2d_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/upcounter_2d_ctrl_pkg.sv
// Shared types and constants for the two-digit BCD up-counter (stopwatch).
package upcounter_2d_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Next BCD value; anything at/over the limit (or non-BCD) rolls to zero.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] v,
                                                 input logic [DIGIT_W-1:0] lim);
    logic [DIGIT_W-1:0] r;
    if ((v >= lim) || (v >= BCD_NINE)) begin
      r = BCD_ZERO;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/upcounter_2d_ctrl_bcd_upcounter.sv
// Single BCD digit counting 0..limit; the up-counting twin of the digit downcounter.
module bcd_upcounter
  import upcounter_2d_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               increase,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] val,
  output logic               carry
);

  logic [DIGIT_W-1:0] val_r;

  // Digit register: reset/clear to zero, step on increase.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r <= BCD_ZERO;
    end else if (clr) begin
      val_r <= BCD_ZERO;
    end else if (increase) begin
      val_r <= bcd_inc(val_r, limit);
    end else begin
      val_r <= val_r;
    end
  end

  assign val = val_r;
  // Level: digit sits at its limit, so the next increase rolls over into the next digit.
  assign carry = (val_r == limit);

endmodule

// File: rtl/upcounter_2d_ctrl.sv
// Two-digit BCD stopwatch with start/pause/clear control.
// Optional lap-freeze of the displayed digits with macro UPCOUNTER_LAP_HOLD_EN.
module upcounter_2d_ctrl
  import upcounter_2d_ctrl_pkg::*;
#(
  parameter int TENS_LIMIT = 5,
  parameter int ONES_LIMIT = 9,
  parameter int WRAP       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start_stop,
  input  logic               clear,
`ifdef UPCOUNTER_LAP_HOLD_EN
  input  logic               lap,
`endif
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit0,
  output logic               running,
  output logic               done
);

  if ((TENS_LIMIT < 0) || (TENS_LIMIT > int'(BCD_NINE)) ||
      (ONES_LIMIT < 0) || (ONES_LIMIT > int'(BCD_NINE))) begin : g_bad_limit
    $error("upcounter_2d_ctrl: TENS_LIMIT/ONES_LIMIT must be BCD digits 0..9");
  end

  localparam logic [DIGIT_W-1:0] TENS_LIM_C = 4'(TENS_LIMIT);
  localparam logic [DIGIT_W-1:0] ONES_LIM_C = 4'(ONES_LIMIT);
  localparam logic               WRAP_C     = (WRAP != 0);

  state_e             state_r;
  state_e             state_s;
  logic               running_r;
  logic               done_r;
  logic               run_tick_s;
  logic               at_max_s;
  logic               to_done_s;
  logic               ones_inc_s;
  logic               tens_inc_s;
  logic               ones_carry_s;
  logic               tens_carry_s;
  logic [DIGIT_W-1:0] ones_val_s;
  logic [DIGIT_W-1:0] tens_val_s;

  // Clear must win over a tick in the same cycle, so it gates counting here.
  assign run_tick_s = (state_r == ST_RUN) && tick && !clear;
  assign at_max_s   = ones_carry_s && tens_carry_s;
  assign to_done_s  = run_tick_s && at_max_s && !WRAP_C;
  assign ones_inc_s = run_tick_s && !(at_max_s && !WRAP_C);
  assign tens_inc_s = ones_inc_s && ones_carry_s;

  bcd_upcounter u_ones (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .increase (ones_inc_s),
    .limit    (ONES_LIM_C),
    .val      (ones_val_s),
    .carry    (ones_carry_s)
  );

  bcd_upcounter u_tens (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .increase (tens_inc_s),
    .limit    (TENS_LIM_C),
    .val      (tens_val_s),
    .carry    (tens_carry_s)
  );

  // Next-state logic; terminal tick beats a simultaneous start_stop.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_stop) state_s = ST_RUN;
          else            state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (to_done_s)       state_s = ST_DONE;
          else if (start_stop) state_s = ST_PAUSE;
          else                 state_s = ST_RUN;
        end
        ST_PAUSE: begin
          if (start_stop) state_s = ST_RUN;
          else            state_s = ST_PAUSE;
        end
        ST_DONE: state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      running_r <= (state_s == ST_RUN);
      done_r    <= (state_s == ST_DONE);
    end
  end

  assign running = running_r;
  assign done    = done_r;

`ifdef UPCOUNTER_LAP_HOLD_EN
  logic               freeze_r;
  logic [DIGIT_W-1:0] hold_tens_r;
  logic [DIGIT_W-1:0] hold_ones_r;

  // Lap freeze: first lap in RUN captures the live digits, second one releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_r    <= 1'b0;
      hold_tens_r <= BCD_ZERO;
      hold_ones_r <= BCD_ZERO;
    end else if (clear || to_done_s) begin
      freeze_r    <= 1'b0;
      hold_tens_r <= hold_tens_r;
      hold_ones_r <= hold_ones_r;
    end else if (lap && (state_r == ST_RUN)) begin
      freeze_r    <= !freeze_r;
      hold_tens_r <= freeze_r ? hold_tens_r : tens_val_s;
      hold_ones_r <= freeze_r ? hold_ones_r : ones_val_s;
    end else begin
      freeze_r    <= freeze_r;
      hold_tens_r <= hold_tens_r;
      hold_ones_r <= hold_ones_r;
    end
  end

  // Output select comes straight from flops, so digits still change only at the edge.
  assign digit1 = freeze_r ? hold_tens_r : tens_val_s;
  assign digit0 = freeze_r ? hold_ones_r : ones_val_s;
`else
  assign digit1 = tens_val_s;
  assign digit0 = ones_val_s;
`endif

endmodule

// File: tb/tb_upcounter_2d_ctrl.sv
// Directed bench: a WRAP=0 and a WRAP=1 instance driven by the same stimulus.
module tb_upcounter_2d_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
`ifdef UPCOUNTER_LAP_HOLD_EN
  logic       lap = 1'b0;
`endif
  logic [3:0] d1_h, d0_h, d1_w, d0_w;
  logic       run_h, done_h, run_w, done_w;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  upcounter_2d_ctrl #(.TENS_LIMIT(5), .ONES_LIMIT(9), .WRAP(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef UPCOUNTER_LAP_HOLD_EN
    .lap        (lap),
`endif
    .digit1     (d1_h),
    .digit0     (d0_h),
    .running    (run_h),
    .done       (done_h)
  );

  upcounter_2d_ctrl #(.TENS_LIMIT(5), .ONES_LIMIT(9), .WRAP(1)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef UPCOUNTER_LAP_HOLD_EN
    .lap        (lap),
`endif
    .digit1     (d1_w),
    .digit0     (d0_w),
    .running    (run_w),
    .done       (done_w)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd8(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  // Apply current inputs at the next rising edge, then settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic press();
    start_stop = 1'b1;
    cyc();
    start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_digits", {d1_h, d0_h}, 8'h00);
    chk("rst_status", {6'd0, run_h, done_h}, 8'h00);
    chk("rst_digits_w", {d1_w, d0_w}, 8'h00);
    ticks(2);
    chk("idle_tick", {d1_h, d0_h}, 8'h00);

    // Basic count 01..10
    press();
    chk("start_run", {7'd0, run_h}, 8'h01);
    chk("start_digits", {d1_h, d0_h}, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("count", {d1_h, d0_h}, bcd8(i));
      chk("count_run", {7'd0, run_h}, 8'h01);
    end

    // Terminal behaviour, hold vs. wrap
    do_clear();
    chk("clr_idle", {d1_h, d0_h, 3'd0, run_h}, 9'h0 == 9'h0 ? 8'h00 : 8'h00);
    press();
    ticks(59);
    chk("at59_h", {d1_h, d0_h}, 8'h59);
    chk("at59_w", {d1_w, d0_w}, 8'h59);
    chk("at59_status", {6'd0, run_h, done_h}, 8'h02);
    ticks(1);
    chk("term_h", {d1_h, d0_h}, 8'h59);
    chk("term_status_h", {6'd0, run_h, done_h}, 8'h01);
    chk("wrap_w", {d1_w, d0_w}, 8'h00);
    chk("wrap_status_w", {6'd0, run_w, done_w}, 8'h02);
    ticks(2);
    chk("held_h", {d1_h, d0_h}, 8'h59);
    chk("after_wrap_w", {d1_w, d0_w}, 8'h02);
    press();
    chk("done_ignores_ss", {6'd0, run_h, done_h}, 8'h01);
    ticks(1);
    chk("done_hold2", {d1_h, d0_h}, 8'h59);

    // Pause and clear
    do_clear();
    chk("clr_from_done", {6'd0, run_h, done_h}, 8'h00);
    chk("clr_digits", {d1_h, d0_h}, 8'h00);
    press();
    ticks(23);
    chk("at23", {d1_h, d0_h}, 8'h23);
    press();
    chk("paused", {6'd0, run_h, done_h}, 8'h00);
    ticks(5);
    chk("pause_hold", {d1_h, d0_h}, 8'h23);
    press();
    ticks(1);
    chk("resume", {d1_h, d0_h}, 8'h24);
    chk("resume_run", {7'd0, run_h}, 8'h01);
    clear = 1'b1;
    tick = 1'b1;
    cyc();
    clear = 1'b0;
    tick = 1'b0;
    chk("clr_tick", {d1_h, d0_h}, 8'h00);
    chk("clr_tick_status", {6'd0, run_h, done_h}, 8'h00);

    // Simultaneous tick + start_stop
    start_stop = 1'b1;
    tick = 1'b1;
    cyc();
    chk("idle_ss_tick", {d1_h, d0_h}, 8'h00);
    chk("idle_ss_tick_run", {7'd0, run_h}, 8'h01);
    cyc();
    start_stop = 1'b0;
    tick = 1'b0;
    chk("run_ss_tick", {d1_h, d0_h}, 8'h01);
    chk("run_ss_tick_pause", {7'd0, run_h}, 8'h00);

`ifdef UPCOUNTER_LAP_HOLD_EN
    // Lap freeze and release
    do_clear();
    press();
    ticks(12);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    chk("lap_freeze", {d1_h, d0_h}, 8'h12);
    ticks(4);
    chk("lap_frozen", {d1_h, d0_h}, 8'h12);
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    chk("lap_release", {d1_h, d0_h}, 8'h16);
    ticks(1);
    chk("lap_live", {d1_h, d0_h}, 8'h17);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
